// File: rtl/uart_cmd_pkg.sv
// Shared state encoding, default header and checksum helper for the
// UART command-frame parser.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    GET_SUM  = 3'd3,
    COMMIT   = 3'd4
  } state_e;

  localparam logic [7:0] DEF_HEADER = 8'hAA;

  // 8-bit running sum, carry discarded
  function automatic logic [7:0] checksum(input logic [7:0] hdr,
                                          input logic [7:0] addr,
                                          input logic [7:0] data);
    return hdr + addr + data;
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte gap counter: counts while run is high, pulses expired for one
// cycle when the gap reaches LIMIT cycles. clr always wins over expiry.
module uart_byte_timer #(
  parameter int LIMIT = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [23:0] cnt;

  assign expired = run & ~clr & (cnt == 24'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || expired) cnt <= '0;
    else if (run)              cnt <= cnt + 24'd1;
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses HEADER/ADDR/DATA/SUM frames from the UART receiver and issues one
// register write per valid frame; bad or stalled frames pulse frame_err.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int          CLK_FREQ   = 50000000,
  parameter int          TIMEOUT_US = 2000,
  parameter logic [7:0]  HEADER     = DEF_HEADER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       reg_wr_en,
  output logic [3:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam int LIMIT = CLK_FREQ / 1000000 * TIMEOUT_US;

  state_e     state, state_nxt;
  logic       rx_done_d;
  logic       byte_evt;
  logic [7:0] addr_q, data_q;
  logic       sum_ok;
  logic       expired;
  logic       tmr_clr, tmr_run;

  // rx_done_d resets high so a done level held across reset is not a new byte
  always_ff @(posedge clk) begin
    if (rst) rx_done_d <= 1'b1;
    else     rx_done_d <= rx_done;
  end

  assign byte_evt = rx_done & ~rx_done_d;
  assign sum_ok   = (rx_data == checksum(HEADER, addr_q, data_q)) &&
                    (addr_q[7:4] == 4'h0);

  assign tmr_run = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_SUM);
  assign tmr_clr = byte_evt || !tmr_run;

  uart_byte_timer #(.LIMIT(LIMIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .run     (tmr_run),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, COMMIT: state_nxt = (byte_evt && rx_data == HEADER) ? GET_ADDR : IDLE;
      GET_ADDR:     if (byte_evt) state_nxt = GET_DATA; else if (expired) state_nxt = IDLE;
      GET_DATA:     if (byte_evt) state_nxt = GET_SUM;  else if (expired) state_nxt = IDLE;
      GET_SUM:      if (byte_evt) state_nxt = sum_ok ? COMMIT : IDLE;
                    else if (expired) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    reg_wr_en = (state == COMMIT);
    frame_ok  = (state == COMMIT);
    busy      = (state != IDLE);
  end

  // Frame fields, write outputs and the error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      data_q      <= '0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= (state == GET_SUM && byte_evt && !sum_ok) || expired;
      if (state == GET_ADDR && byte_evt) addr_q <= rx_data;
      if (state == GET_DATA && byte_evt) data_q <= rx_data;
      if (state == GET_SUM && byte_evt && sum_ok) begin
        reg_wr_addr <= addr_q[3:0];
        reg_wr_data <= data_q;
      end
    end
  end

endmodule
